// File: rtl/delay_pkg.sv
// Shared types and helpers for the timestamp-based pulse delay.
// Holds default sizes and the pointer-width function.
package delay_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int DEPTH_DEF = 8;

   typedef logic [CNT_W_DEF-1:0] ts_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/ts_fifo.sv
// Synchronous FIFO of expiry timestamps.
// Push into a full FIFO is taken when a pop happens in the same cycle.
module ts_fifo
   import delay_pkg::*;
#(
   parameter int W     = CNT_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW   = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic [W-1:0]  head
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign level   = cnt;
   assign head    = mem[rd_ptr];
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/delay_sched.sv
// Runtime-programmable pulse delay: each input event stores its
// expiry timestamp and is emitted when the free-running timer reaches it.
module delay_sched
   import delay_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int LW   = clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   output logic             dout,
   input  logic [CNT_W-1:0] cfg_delay,
   output logic [CNT_W-1:0] cur_delay,
   input  logic             flush,
   output logic             busy,
   output logic [LW-1:0]    level,
   output logic             ovf,
   input  logic             ovf_clr
);

   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] tmr_nxt;
   logic [CNT_W-1:0] expiry;
   logic [CNT_W-1:0] head;
   logic [CNT_W-1:0] cfg_clamp;
   logic             full;
   logic             empty;
   logic             ev;
   logic             bypass;
   logic             pop;
   logic             push;
   logic             drop;
   logic             idle;

   assign tmr_nxt = timer + 1'b1;
   assign expiry  = timer + cur_delay;
   assign ev      = din & ~flush;

   // A one-cycle delay cannot round-trip through the FIFO; the FIFO is
   // always empty while cur_delay is 1, so the event goes straight out.
   assign bypass  = ev & (cur_delay == CNT_W'(1));

   // Popping on timer+1 lands dout one edge earlier, so D stages total.
   assign pop     = ~flush & ~empty & (head == tmr_nxt);
   assign push    = ev & ~bypass & (~full | pop);
   assign drop    = ev & ~bypass & full & ~pop;
   assign idle    = empty & ~din & ~pop;

   assign cfg_clamp = (cfg_delay == '0) ? CNT_W'(1) : cfg_delay;
   assign busy      = (level != '0);

   ts_fifo #(
      .W     (CNT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (expiry),
      .full  (full),
      .empty (empty),
      .level (level),
      .head  (head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer     <= '0;
         dout      <= 1'b0;
         cur_delay <= CNT_W'(1);
         ovf       <= 1'b0;
      end else begin
         timer <= tmr_nxt;
         dout  <= ~flush & (pop | bypass);
         if (idle) cur_delay <= cfg_clamp;
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_delay_sched.sv
// Directed checks of delay_sched: timing, overflow, delay update,
// flush, reset and timer wrap.
module tb_delay_sched;
   import delay_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din = 1'b0;
   logic        dout;
   logic [15:0] cfg_delay = 16'd1;
   logic [15:0] cur_delay;
   logic        flush = 1'b0;
   logic        busy;
   logic [3:0]  level;
   logic        ovf;
   logic        ovf_clr = 1'b0;

   int pass_cnt = 0;
   int total = 0;

   always #5 clk = ~clk;

   delay_sched dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .dout      (dout),
      .cfg_delay (cfg_delay),
      .cur_delay (cur_delay),
      .flush     (flush),
      .busy      (busy),
      .level     (level),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      tick(2);
      total++;
      if ({dout, busy, level, ovf} !== 7'd0) begin
         $display("FAIL reset_outs got=%b want=0",
                  {dout, busy, level, ovf});
      end else pass_cnt++;
      total++;
      if (cur_delay !== 16'd1) begin
         $display("FAIL reset_cur got=%0d want=1", cur_delay);
      end else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_unit_delay;
      tick(9);
      total++;
      if (dout !== 1'b0) begin
         $display("FAIL d1_pre got=%b want=0", dout);
      end else pass_cnt++;
      din = 1'b1;
      tick(1);
      din = 1'b0;
      total++;
      if (dout !== 1'b1) begin
         $display("FAIL d1_out got=%b want=1", dout);
      end else pass_cnt++;
      tick(1);
      total++;
      if (dout !== 1'b0) begin
         $display("FAIL d1_post got=%b want=0", dout);
      end else pass_cnt++;
      cfg_delay = 16'd5;
      tick(2);
      total++;
      if (cur_delay !== 16'd5) begin
         $display("FAIL cur5 got=%0d want=5", cur_delay);
      end else pass_cnt++;
      cfg_delay = 16'd0;
      tick(2);
      total++;
      if (cur_delay !== 16'd1) begin
         $display("FAIL clamp got=%0d want=1", cur_delay);
      end else pass_cnt++;
      din = 1'b1;
      tick(1);
      din = 1'b0;
      total++;
      if (dout !== 1'b1) begin
         $display("FAIL d0_out got=%b want=1", dout);
      end else pass_cnt++;
      tick(1);
      total++;
      if (dout !== 1'b0) begin
         $display("FAIL d0_post got=%b want=0", dout);
      end else pass_cnt++;
   endtask

   task automatic test_long_delay;
      int ones;
      int idle_busy;
      ones = 0;
      idle_busy = 0;
      cfg_delay = 16'd1000;
      tick(2);
      total++;
      if (cur_delay !== 16'd1000) begin
         $display("FAIL cur1000 got=%0d want=1000", cur_delay);
      end else pass_cnt++;
      din = 1'b1;
      tick(1);
      din = 1'b0;
      total++;
      if ({busy, level} !== 5'b1_0001) begin
         $display("FAIL long_busy got=%b want=10001", {busy, level});
      end else pass_cnt++;
      for (int i = 0; i < 998; i++) begin
         tick(1);
         if (dout) ones++;
         if (!busy || level > 4'd1) idle_busy++;
      end
      total++;
      if (ones != 0 || idle_busy != 0) begin
         $display("FAIL long_wait ones=%0d badbusy=%0d want=0,0",
                  ones, idle_busy);
      end else pass_cnt++;
      tick(1);
      total++;
      if ({dout, busy, level} !== 6'b10_0000) begin
         $display("FAIL long_out got=%b want=100000",
                  {dout, busy, level});
      end else pass_cnt++;
      tick(1);
      total++;
      if (dout !== 1'b0) begin
         $display("FAIL long_post got=%b want=0", dout);
      end else pass_cnt++;
   endtask

   task automatic test_burst_ovf;
      int ones;
      ones = 0;
      cfg_delay = 16'd50;
      tick(2);
      din = 1'b1;
      tick(8);
      total++;
      if ({level, ovf} !== 5'b1000_0) begin
         $display("FAIL burst_full got=%b want=10000", {level, ovf});
      end else pass_cnt++;
      tick(1);
      total++;
      if (ovf !== 1'b1) begin
         $display("FAIL ovf_set got=%b want=1", ovf);
      end else pass_cnt++;
      ovf_clr = 1'b1;
      tick(1);
      din = 1'b0;
      ovf_clr = 1'b0;
      total++;
      if ({ovf, level} !== 5'b1_1000) begin
         $display("FAIL ovf_setwins got=%b want=11000", {ovf, level});
      end else pass_cnt++;
      for (int i = 0; i < 39; i++) begin
         tick(1);
         if (dout) ones++;
      end
      total++;
      if (ones != 0) begin
         $display("FAIL burst_early ones=%0d want=0", ones);
      end else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (dout) ones++;
      end
      total++;
      if (ones != 8) begin
         $display("FAIL burst_train ones=%0d want=8", ones);
      end else pass_cnt++;
      tick(1);
      total++;
      if ({dout, level} !== 5'd0) begin
         $display("FAIL burst_end got=%b want=0", {dout, level});
      end else pass_cnt++;
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      total++;
      if (ovf !== 1'b0) begin
         $display("FAIL ovf_clr got=%b want=0", ovf);
      end else pass_cnt++;
   endtask

   task automatic test_delay_change;
      int bad;
      int ones;
      bad = 0;
      ones = 0;
      cfg_delay = 16'd100;
      tick(2);
      for (int e = 0; e < 5; e++) begin
         din = (e % 2 == 0);
         tick(1);
         cfg_delay = 16'd10;
      end
      din = 1'b0;
      total++;
      if ({cur_delay, level} !== {16'd100, 4'd3}) begin
         $display("FAIL chg_pend cur=%0d lvl=%0d want=100,3",
                  cur_delay, level);
      end else pass_cnt++;
      for (int e = 5; e <= 110; e++) begin
         tick(1);
         if (dout !== (e == 99 || e == 101 || e == 103)) bad++;
         if (e == 103 && cur_delay !== 16'd100) bad++;
         if (e == 104 && cur_delay !== 16'd10) bad++;
      end
      total++;
      if (bad != 0) begin
         $display("FAIL chg_drain errs=%0d want=0", bad);
      end else pass_cnt++;
      din = 1'b1;
      tick(1);
      din = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (dout) ones++;
      end
      tick(1);
      total++;
      if (ones != 0 || dout !== 1'b1) begin
         $display("FAIL chg_new ones=%0d dout=%b want=0,1",
                  ones, dout);
      end else pass_cnt++;
      tick(1);
   endtask

   task automatic test_flush;
      int ones;
      ones = 0;
      din = 1'b1;
      tick(4);
      total++;
      if (level !== 4'd4) begin
         $display("FAIL fl_pre got=%0d want=4", level);
      end else pass_cnt++;
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      din = 1'b0;
      total++;
      if ({level, busy, dout} !== 6'd0) begin
         $display("FAIL fl_clear got=%b want=0", {level, busy, dout});
      end else pass_cnt++;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (dout) ones++;
      end
      total++;
      if (ones != 0) begin
         $display("FAIL fl_after ones=%0d want=0", ones);
      end else pass_cnt++;
   endtask

   task automatic test_mid_reset;
      int ones;
      ones = 0;
      din = 1'b1;
      tick(3);
      din = 1'b0;
      tick(7);
      total++;
      if (dout !== 1'b1) begin
         $display("FAIL mr_pre got=%b want=1", dout);
      end else pass_cnt++;
      rst = 1'b1;
      #1;
      total++;
      if ({dout, busy, level, ovf} !== 7'd0 || cur_delay !== 16'd1) begin
         $display("FAIL mr_async got=%b cur=%0d want=0,1",
                  {dout, busy, level, ovf}, cur_delay);
      end else pass_cnt++;
      tick(1);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (dout) ones++;
      end
      total++;
      if (ones != 0) begin
         $display("FAIL mr_after ones=%0d want=0", ones);
      end else pass_cnt++;
   endtask

   task automatic test_wrap;
      int ones;
      ts_t start;
      ones = 0;
      start = 16'd65530;
      rst = 1'b1;
      cfg_delay = 16'd20;
      tick(1);
      rst = 1'b0;
      tick(int'(start));
      total++;
      if (cur_delay !== 16'd20) begin
         $display("FAIL wr_cur got=%0d want=20", cur_delay);
      end else pass_cnt++;
      din = 1'b1;
      tick(1);
      din = 1'b0;
      for (int i = 0; i < 18; i++) begin
         tick(1);
         if (dout) ones++;
      end
      tick(1);
      total++;
      if (ones != 0 || dout !== 1'b1) begin
         $display("FAIL wr_out ones=%0d dout=%b want=0,1", ones, dout);
      end else pass_cnt++;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (dout) ones++;
      end
      total++;
      if (ones != 0 || busy !== 1'b0) begin
         $display("FAIL wr_after ones=%0d busy=%b want=0,0", ones, busy);
      end else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_unit_delay;
      test_long_delay;
      test_burst_ovf;
      test_delay_change;
      test_flush;
      test_mid_reset;
      test_wrap;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
